// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I ALU issue sequencer: opcodes, funct fields,
// FSM state codes and the I-type immediate helper.
package rv32i_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;
   localparam logic [1:0] ST_WB   = 2'd3;

   function automatic logic [31:0] immI(input logic [31:0] instrWord);
      return {{20{instrWord[31]}}, instrWord[31:20]};
   endfunction

endpackage

// File: rtl/rv32i_alu_sequencer_if.sv
// Issue-side bus of the sequencer: instruction handshake, ALU drive/return and writeback.
interface rv32i_alu_sequencer_if;

   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] alu_op_a;
   logic [31:0] alu_op_b;
   logic [2:0]  alu_funct3;
   logic        alu_op_sign;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        alu_negative;
   logic        alu_overflow;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [2:0]  wb_flags;
   logic        illegal;

   modport slave (
      input  instr_valid, instr, alu_result, alu_zero, alu_negative, alu_overflow,
      output instr_ready, alu_op_a, alu_op_b, alu_funct3, alu_op_sign,
             wb_valid, wb_rd, wb_data, wb_flags, illegal
   );

   modport master (
      output instr_valid, instr, alu_result, alu_zero, alu_negative, alu_overflow,
      input  instr_ready, alu_op_a, alu_op_b, alu_funct3, alu_op_sign,
             wb_valid, wb_rd, wb_data, wb_flags, illegal
   );

endinterface

// File: rtl/rv32i_regfile.sv
// 32-entry register file: two async operand reads, one async debug read,
// one synchronous write; x0 always reads zero and is never written.
module rv32i_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   i_rs1Addr,
   output logic [XLEN-1:0] o_rs1Data,
   input  logic [AW-1:0]   i_rs2Addr,
   output logic [XLEN-1:0] o_rs2Data,
   input  logic [AW-1:0]   i_dbgAddr,
   output logic [XLEN-1:0] o_dbgData,
   input  logic            i_wrEn,
   input  logic [AW-1:0]   i_wrAddr,
   input  logic [XLEN-1:0] i_wrData
);

   logic [XLEN-1:0] r_regs [NREGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_wrEn && (i_wrAddr != '0)) begin
         r_regs[i_wrAddr] <= i_wrData;
      end
   end

   assign o_rs1Data = (i_rs1Addr == '0) ? '0 : r_regs[i_rs1Addr];
   assign o_rs2Data = (i_rs2Addr == '0) ? '0 : r_regs[i_rs2Addr];
   assign o_dbgData = (i_dbgAddr == '0) ? '0 : r_regs[i_dbgAddr];

endmodule

// File: rtl/rv32i_alu_sequencer.sv
// Multi-cycle issue sequencer for the combinational RV32I ALU:
// IDLE -> READ (decode, operand fetch) -> EXEC (ALU settles) -> WB (register write).
module rv32i_alu_sequencer
   import rv32i_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   rv32i_alu_sequencer_if.slave  bus,
   input  logic [4:0]            dbg_addr,
   output logic [XLEN-1:0]       dbg_data
);

   logic [1:0]      r_state;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_opA;
   logic [XLEN-1:0] r_opB;
   logic [2:0]      r_funct3;
   logic            r_opSign;
   logic            r_wbValid;
   logic [4:0]      r_wbRd;
   logic [XLEN-1:0] r_wbData;
   logic [2:0]      r_wbFlags;
   logic            r_illegal;

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_rs1Data;
   logic [XLEN-1:0] w_rs2Data;
   logic            w_legal;
   logic            w_sign;

   assign w_opcode = r_instr[6:0];
   assign w_rd     = r_instr[11:7];
   assign w_funct3 = r_instr[14:12];
   assign w_rs1    = r_instr[19:15];
   assign w_rs2    = r_instr[24:20];
   assign w_funct7 = r_instr[31:25];

   rv32i_regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (5)
   ) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .i_rs1Addr (w_rs1),
      .o_rs1Data (w_rs1Data),
      .i_rs2Addr (w_rs2),
      .o_rs2Data (w_rs2Data),
      .i_dbgAddr (dbg_addr),
      .o_dbgData (dbg_data),
      .i_wrEn    (r_state == ST_WB),
      .i_wrAddr  (r_wbRd),
      .i_wrData  (r_wbData)
   );

   // Legality and SUB/SRA select; OP-IMM shifts reuse funct7 bits of the immediate.
   always_comb begin
      w_legal = 1'b0;
      w_sign  = 1'b0;
      case (w_opcode)
         OPC_OP: begin
            if (w_funct7 == F7_BASE) begin
               w_legal = 1'b1;
            end else if ((w_funct7 == F7_ALT) && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR))) begin
               w_legal = 1'b1;
               w_sign  = 1'b1;
            end
         end
         OPC_OPIMM: begin
            case (w_funct3)
               F3_SLL:  w_legal = (w_funct7 == F7_BASE);
               F3_SR: begin
                  w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                  w_sign  = r_instr[30];
               end
               default: w_legal = 1'b1;
            endcase
         end
         default: begin
            w_legal = 1'b0;
            w_sign  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_instr   <= '0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_funct3  <= '0;
         r_opSign  <= 1'b0;
         r_wbValid <= 1'b0;
         r_wbRd    <= '0;
         r_wbData  <= '0;
         r_wbFlags <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_wbValid <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.instr_valid) begin
                  r_instr <= bus.instr;
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               if (w_legal) begin
                  r_opA    <= w_rs1Data;
                  r_opB    <= (w_opcode == OPC_OP) ? w_rs2Data : immI(r_instr);
                  r_funct3 <= w_funct3;
                  r_opSign <= w_sign;
                  r_state  <= ST_EXEC;
               end else begin
                  r_illegal <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               r_wbData  <= bus.alu_result;
               r_wbFlags <= {bus.alu_zero, bus.alu_negative, bus.alu_overflow};
               r_wbRd    <= w_rd;
               r_wbValid <= 1'b1;
               r_state   <= ST_WB;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.instr_ready = (r_state == ST_IDLE);
   assign bus.alu_op_a    = r_opA;
   assign bus.alu_op_b    = r_opB;
   assign bus.alu_funct3  = r_funct3;
   assign bus.alu_op_sign = r_opSign;
   assign bus.wb_valid    = r_wbValid;
   assign bus.wb_rd       = r_wbRd;
   assign bus.wb_data     = r_wbData;
   assign bus.wb_flags    = r_wbFlags;
   assign bus.illegal     = r_illegal;

endmodule

// File: tb/tb_rv32i_alu_sequencer.sv
// Directed bench for rv32i_alu_sequencer with a behavioural RV32I ALU closing the loop.
module tb_rv32i_alu_sequencer;

   logic        clk;
   logic        reset;
   logic [4:0]  dbgAddr;
   logic [31:0] dbgData;
   int          totalChecks;
   int          badChecks;

   rv32i_alu_sequencer_if bus ();

   rv32i_alu_sequencer dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .dbg_addr (dbgAddr),
      .dbg_data (dbgData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU driven straight from the sequencer's registered operands.
   always_comb begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        ov;
      a  = bus.alu_op_a;
      b  = bus.alu_op_b;
      r  = '0;
      ov = 1'b0;
      case (bus.alu_funct3)
         3'b000: begin
            if (bus.alu_op_sign) begin
               r  = a - b;
               ov = (a[31] != b[31]) && (r[31] != a[31]);
            end else begin
               r  = a + b;
               ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
         end
         3'b001: r = a << b[4:0];
         3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b011: r = (a < b) ? 32'd1 : 32'd0;
         3'b100: r = a ^ b;
         3'b101: r = bus.alu_op_sign ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'b110: r = a | b;
         default: r = a & b;
      endcase
      bus.alu_result   = r;
      bus.alu_zero     = (r == 32'd0);
      bus.alu_negative = r[31];
      bus.alu_overflow = ov;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got=%h want=%h", tag, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkReg(input logic [4:0] addr, input logic [31:0] expected);
      dbgAddr = addr;
      #1;
      checkOutput($sformatf("dbg x%0d", addr), dbgData, expected);
   endtask

   // Offers one instruction and returns 1ns after the accepting edge (READ cycle).
   task automatic applyStimulus(input logic [31:0] word);
      bit accepted;
      accepted = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.instr_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) begin
         checkOutput("handshake timeout", 32'd0, 32'd1);
      end
      bus.instr_valid = 1'b1;
      bus.instr       = word;
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr       = $urandom;
      checkOutput("ready in READ", 32'(bus.instr_ready), 32'd0);
   endtask

   task automatic runLegal(input logic [31:0] word, input logic expSign, input logic [2:0] expF3,
                           input logic [31:0] expOpB, input logic [4:0] expRd,
                           input logic [31:0] expData, input logic [2:0] expFlags);
      applyStimulus(word);
      stepCycle();
      checkOutput("exec op_sign", 32'(bus.alu_op_sign), 32'(expSign));
      checkOutput("exec funct3", 32'(bus.alu_funct3), 32'(expF3));
      checkOutput("exec op_b", bus.alu_op_b, expOpB);
      checkOutput("exec wb_valid", 32'(bus.wb_valid), 32'd0);
      stepCycle();
      checkOutput("wb_valid", 32'(bus.wb_valid), 32'd1);
      checkOutput("wb_rd", 32'(bus.wb_rd), 32'(expRd));
      checkOutput("wb_data", bus.wb_data, expData);
      checkOutput("wb_flags", 32'(bus.wb_flags), 32'(expFlags));
      checkOutput("wb ready", 32'(bus.instr_ready), 32'd0);
      stepCycle();
      checkOutput("idle ready", 32'(bus.instr_ready), 32'd1);
      checkOutput("idle wb_valid", 32'(bus.wb_valid), 32'd0);
   endtask

   // Operands left by the previous legal instruction must survive a rejection.
   task automatic runIllegal(input logic [31:0] word, input logic [31:0] holdOpB);
      applyStimulus(word);
      stepCycle();
      checkOutput("illegal pulse", 32'(bus.illegal), 32'd1);
      checkOutput("illegal wb_valid", 32'(bus.wb_valid), 32'd0);
      checkOutput("illegal ready", 32'(bus.instr_ready), 32'd1);
      checkOutput("illegal op_b held", bus.alu_op_b, holdOpB);
      stepCycle();
      checkOutput("illegal cleared", 32'(bus.illegal), 32'd0);
      checkOutput("illegal no wb", 32'(bus.wb_valid), 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " ready"}, 32'(bus.instr_ready), 32'd1);
      checkOutput({tag, " op_a"}, bus.alu_op_a, 32'd0);
      checkOutput({tag, " op_b"}, bus.alu_op_b, 32'd0);
      checkOutput({tag, " funct3/sign"}, 32'({bus.alu_funct3, bus.alu_op_sign}), 32'd0);
      checkOutput({tag, " wb_valid"}, 32'(bus.wb_valid), 32'd0);
      checkOutput({tag, " wb_rd/flags"}, 32'({bus.wb_rd, bus.wb_flags}), 32'd0);
      checkOutput({tag, " wb_data"}, bus.wb_data, 32'd0);
      checkOutput({tag, " illegal"}, 32'(bus.illegal), 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      totalChecks     = 0;
      badChecks       = 0;
      reset           = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      dbgAddr         = '0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("in reset");
      @(negedge clk);
      reset = 1'b0;
      stepCycle();
      checkResetOutputs("after reset");
      checkReg(5'd1, 32'd0);

      // ADDI x1,x0,12
      runLegal(32'h00C00093, 1'b0, 3'b000, 32'h0000000C, 5'd1, 32'h0000000C, 3'b000);
      checkReg(5'd1, 32'h0000000C);
      // ADDI x2,x0,13 then SUB x3,x1,x2
      runLegal(32'h00D00113, 1'b0, 3'b000, 32'h0000000D, 5'd2, 32'h0000000D, 3'b000);
      runLegal(32'h402081B3, 1'b1, 3'b000, 32'h0000000D, 5'd3, 32'hFFFFFFFF, 3'b010);
      checkReg(5'd3, 32'hFFFFFFFF);
      // ADDI x4,x0,-4 then SRAI x5,x4,1 (immediate 0x401, shamt 1)
      runLegal(32'hFFC00213, 1'b0, 3'b000, 32'hFFFFFFFC, 5'd4, 32'hFFFFFFFC, 3'b010);
      runLegal(32'h40125293, 1'b1, 3'b101, 32'h00000401, 5'd5, 32'hFFFFFFFE, 3'b010);
      checkReg(5'd5, 32'hFFFFFFFE);
      // ADDI x0,x0,5: writeback pulses but x0 stays zero
      runLegal(32'h00500013, 1'b0, 3'b000, 32'h00000005, 5'd0, 32'h00000005, 3'b000);
      checkReg(5'd0, 32'd0);

      // LOAD opcode, OP with funct7=0000001, SLLI with funct7=0100000
      runIllegal(32'h00000003, 32'h00000005);
      runIllegal(32'h02208333, 32'h00000005);
      checkReg(5'd6, 32'd0);
      runIllegal(32'h40109093, 32'h00000005);
      checkReg(5'd1, 32'h0000000C);

      // ADD x7,x1,x1 aborted by reset while in EXEC
      applyStimulus(32'h001083B3);
      stepCycle();
      checkOutput("pre-abort op_a", bus.alu_op_a, 32'h0000000C);
      @(negedge clk);
      reset = 1'b1;
      stepCycle();
      checkResetOutputs("abort");
      checkReg(5'd1, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("abort no wb", 32'(bus.wb_valid), 32'd0);
      end
      checkReg(5'd7, 32'd0);

      // Normal operation resumes after the abort
      runLegal(32'h00C00093, 1'b0, 3'b000, 32'h0000000C, 5'd1, 32'h0000000C, 3'b000);
      checkReg(5'd1, 32'h0000000C);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
